// File: rtl/rf_uart_mailbox_ctrl.sv
// rf_uart_mailbox_ctrl: arbitrates the register file write port between CPU
// writeback and the UART mailboxes. Received bytes queue in a small FIFO and
// are deposited one at a time into RX_REG. CPU writes to TX_REG start a UART
// transmission and are held off while the transmitter is still occupied.
module rf_uart_mailbox_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int RX_REG     = 31,
    parameter int TX_REG     = 30,
    parameter int FIFO_AW    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_waddr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_stall,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_busy,
    output logic                  rx_overflow
);
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [1:0] TX_IDLE      = 2'd0;
    localparam logic [1:0] TX_LOAD      = 2'd1;
    localparam logic [1:0] TX_WAIT_BUSY = 2'd2;
    localparam logic [1:0] TX_WAIT_DONE = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] RX_ADDR = ADDR_WIDTH'(RX_REG);
    localparam logic [ADDR_WIDTH-1:0] TX_ADDR = ADDR_WIDTH'(TX_REG);

    logic [7:0]         fifo_mem [DEPTH];
    logic [FIFO_AW:0]   wr_ptr, rd_ptr;
    logic               fifo_empty, fifo_full;
    logic [7:0]         fifo_head;
    logic               shown, ovf;
    logic [1:0]         tx_state;

    logic               we_int, stall_int;
    logic               tx_accept, rx_pop, deposit, push;

    // The extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr[FIFO_AW-1:0]];

    // A deposit in the same cycle frees the head slot, so a full FIFO still accepts.
    assign push = rx_valid && (!fifo_full || deposit);

    // Write port arbitration: CPU first, deposit only on CPU-idle cycles.
    always_comb begin
        we_int    = 1'b0;
        stall_int = 1'b0;
        rf_waddr  = cpu_waddr;
        rf_wdata  = cpu_wdata;
        tx_accept = 1'b0;
        rx_pop    = 1'b0;
        deposit   = 1'b0;
        if (cpu_we) begin
            if (cpu_waddr == '0) begin
                we_int = 1'b0;
            end else if (cpu_waddr == TX_ADDR) begin
                if (tx_state != TX_IDLE) begin
                    stall_int = 1'b1;
                end else begin
                    we_int    = 1'b1;
                    tx_accept = 1'b1;
                end
            end else if (cpu_waddr == RX_ADDR) begin
                we_int   = 1'b1;
                rf_wdata = '0;
                rx_pop   = 1'b1;
            end else begin
                we_int = 1'b1;
            end
        end else if (!fifo_empty && !shown) begin
            we_int   = 1'b1;
            deposit  = 1'b1;
            rf_waddr = RX_ADDR;
            rf_wdata = {{(DATA_WIDTH-10){1'b0}}, ovf, 1'b1, fifo_head};
        end
    end

    // Outputs stay quiet while reset is held, independent of the inputs.
    assign rf_we       = we_int && rst_n;
    assign cpu_stall   = stall_int && rst_n;
    assign tx_start    = (tx_state == TX_LOAD);
    assign rx_overflow = ovf;

    // FIFO storage; contents are discarded on reset by clearing the pointers.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= rx_data;
    end

    // FIFO pointers, shown flag and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            shown  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + 1'b1;
            if (deposit) rd_ptr <= rd_ptr + 1'b1;
            if (deposit)     shown <= 1'b1;
            else if (rx_pop) shown <= 1'b0;
            // A drop in the same cycle as a pop leaves the flag set.
            if (rx_valid && !push) ovf <= 1'b1;
            else if (rx_pop)       ovf <= 1'b0;
        end
    end

    // TX handshake sequencer; tx_data is captured on an accepted TX write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_data  <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: if (tx_accept) begin
                    tx_state <= TX_LOAD;
                    tx_data  <= cpu_wdata[7:0];
                end
                TX_LOAD:      tx_state <= TX_WAIT_BUSY;
                TX_WAIT_BUSY: if (tx_busy)  tx_state <= TX_WAIT_DONE;
                TX_WAIT_DONE: if (!tx_busy) tx_state <= TX_IDLE;
                default:      tx_state <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rf_uart_mailbox_ctrl.sv
// Bench for rf_uart_mailbox_ctrl: a queue-based mailbox model checked every
// cycle on the falling edge, plus directed literal expectations.
module tb_rf_uart_mailbox_ctrl;
    logic        clk, rst_n;
    logic        cpu_we;
    logic [4:0]  cpu_waddr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy, rx_overflow;

    int nchk = 0;
    int npass = 0;

    rf_uart_mailbox_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .rx_overflow(rx_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else npass++;
    endtask

    // Model: pending bytes, shown/overflow flags, TX phase (0 idle, 1 start
    // pulse, 2 waiting for busy, 3 waiting for done) and the captured byte.
    logic [7:0] q[$];
    bit         shown_m, ovf_m;
    int         ts;
    logic [7:0] tdat_m;

    always @(negedge rst_n) begin
        q.delete(); shown_m = 0; ovf_m = 0; ts = 0; tdat_m = 8'h00;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (!cpu_we && q.size() > 0 && !shown_m) begin
                void'(q.pop_front());
                shown_m = 1;
            end
            if (cpu_we && cpu_waddr == 5'd31) begin shown_m = 0; ovf_m = 0; end
            if (rx_valid) begin
                if (q.size() < 4) q.push_back(rx_data);
                else ovf_m = 1;
            end
            case (ts)
                0: if (cpu_we && cpu_waddr == 5'd30) begin ts = 1; tdat_m = cpu_wdata[7:0]; end
                1: ts = 2;
                2: if (tx_busy) ts = 3;
                default: if (!tx_busy) ts = 0;
            endcase
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        logic        e_we, e_stall;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        if (!rst_n) begin
            check("rst_rf_we", rf_we, 0);
            check("rst_stall", cpu_stall, 0);
            check("rst_tx_start", tx_start, 0);
            check("rst_tx_data", tx_data, 0);
            check("rst_ovf", rx_overflow, 0);
        end else begin
            e_we = 0; e_stall = 0; e_addr = 0; e_data = 0;
            if (cpu_we) begin
                if (cpu_waddr == 5'd0) e_we = 0;
                else if (cpu_waddr == 5'd30) begin
                    if (ts != 0) e_stall = 1;
                    else begin e_we = 1; e_addr = 5'd30; e_data = cpu_wdata; end
                end else if (cpu_waddr == 5'd31) begin
                    e_we = 1; e_addr = 5'd31; e_data = 0;
                end else begin
                    e_we = 1; e_addr = cpu_waddr; e_data = cpu_wdata;
                end
            end else if (q.size() > 0 && !shown_m) begin
                e_we = 1; e_addr = 5'd31; e_data = {22'b0, ovf_m, 1'b1, q[0]};
            end
            check("rf_we", rf_we, e_we);
            check("cpu_stall", cpu_stall, e_stall);
            if (e_we) begin
                check("rf_waddr", rf_waddr, e_addr);
                check("rf_wdata", rf_wdata, e_data);
            end
            check("tx_start", tx_start, ts == 1);
            check("tx_data", tx_data, tdat_m);
            check("rx_overflow", rx_overflow, ovf_m);
        end
    end

    // One cycle of inputs, applied just after the rising edge.
    task automatic cyc(input logic we, input logic [4:0] a, input logic [31:0] d,
                       input logic rv, input logic [7:0] rd);
        @(posedge clk); #1;
        cpu_we = we; cpu_waddr = a; cpu_wdata = d; rx_valid = rv; rx_data = rd;
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 0; cpu_we = 0; cpu_waddr = 0; cpu_wdata = 0;
        rx_valid = 0; rx_data = 0; tx_busy = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // RX single byte
        cyc(0, 0, 0, 1, 8'h41);
        idle();
        check("lit_dep41_we", rf_we, 1);
        check("lit_dep41_addr", rf_waddr, 31);
        check("lit_dep41_data", rf_wdata, 32'h141);
        idle();
        check("lit_shown_no_dep", rf_we, 0);
        cyc(1, 31, 32'hDEAD, 0, 0);
        check("lit_pop_data", rf_wdata, 0);

        // RX contention with CPU writes to reg 5
        cyc(1, 5, 32'h1, 1, 8'h11);
        check("lit_cpu5_addr", rf_waddr, 5);
        cyc(1, 5, 32'h2, 1, 8'h22);
        check("lit_cpu5_data", rf_wdata, 32'h2);
        cyc(1, 5, 32'h3, 0, 0);
        idle();
        check("lit_dep11", rf_wdata, 32'h111);
        idle();
        check("lit_wait_pop", rf_we, 0);
        cyc(1, 31, 32'hFFFF_FFFF, 0, 0);
        check("lit_pop2_addr", rf_waddr, 31);
        check("lit_pop2_data", rf_wdata, 0);
        idle();
        check("lit_dep22", rf_wdata, 32'h122);
        cyc(1, 31, 0, 0, 0);
        idle();

        // RX overflow: A1 shown, A2..A5 buffered, A6 dropped
        for (int i = 1; i <= 6; i++) cyc(0, 0, 0, 1, 8'hA0 + 8'(i));
        idle();
        check("lit_ovf_set", rx_overflow, 1);
        cyc(1, 31, 0, 0, 0);
        cyc(0, 0, 0, 1, 8'hA7);
        check("lit_ovf_clr", rx_overflow, 0);
        check("lit_depA2", rf_wdata, 32'h1A2);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 31, 0, 0, 0);
            idle();
        end
        check("lit_depA7", rf_wdata, 32'h1A7);
        check("lit_no_ovf", rx_overflow, 0);
        cyc(1, 31, 0, 0, 0);

        // Reg 0 is never written
        cyc(1, 0, 32'h1234, 0, 0);
        check("lit_r0_we", rf_we, 0);
        check("lit_r0_stall", cpu_stall, 0);

        // TX
        cyc(1, 30, 32'h1C3, 0, 0);
        check("lit_tx_fwd_we", rf_we, 1);
        check("lit_tx_fwd_data", rf_wdata, 32'h1C3);
        idle();
        check("lit_tx_start", tx_start, 1);
        check("lit_tx_data", tx_data, 8'hC3);
        idle();
        check("lit_tx_start_off", tx_start, 0);
        tx_busy = 1;
        cyc(1, 30, 32'h55, 0, 0);
        check("lit_stall", cpu_stall, 1);
        check("lit_stall_we", rf_we, 0);
        cyc(1, 30, 32'h55, 0, 0);
        check("lit_stall2", cpu_stall, 1);
        tx_busy = 0;
        cyc(1, 30, 32'h55, 0, 0);
        check("lit_accept", rf_we, 1);
        check("lit_accept_stall", cpu_stall, 0);
        idle();
        check("lit_tx2_data", tx_data, 8'h55);
        idle();
        tx_busy = 1;

        // Reset mid-TX with two bytes buffered
        cyc(1, 5, 32'h9, 1, 8'hB1);
        cyc(1, 5, 32'hA, 1, 8'hB2);
        cyc(1, 5, 32'hB, 0, 0);
        #1 rst_n = 0;
        #1;
        check("lit_async_we", rf_we, 0);
        check("lit_async_txd", tx_data, 0);
        idle();
        @(posedge clk); #1;
        rst_n = 1; tx_busy = 0;
        idle();
        check("lit_post_rst_nodep", rf_we, 0);
        idle();
        cyc(1, 30, 32'h7E, 0, 0);
        check("lit_post_rst_tx", rf_we, 1);
        check("lit_post_rst_stall", cpu_stall, 0);
        idle();
        check("lit_post_rst_start", tx_start, 1);
        idle();
        idle();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
